carregador_matriz: RTL and testbench
====================================

// Module: carregador_matriz
// PURPOSE
//  Sequential front end for the determinant ALU: receives matrix elements one per handshake, row-major,
//  and packs them densely onto the 200-bit matriz bus (element k at [8k+7:8k]). Then holds the bus stable
//  for SETTLE_CYCLES, samples det/overflow/done from the ALU, and returns the result via a valid/ready pair.
//  Sits between the host/command decoder and ula_determinante.
// PARAMETERS
//  ELEM_W         8  element width in bits, signed two's complement
//  BUS_W        200  packed matrix bus width (25 elements x ELEM_W)
//  SETTLE_CYCLES  2  cycles the bus is held stable before the result is sampled (1..15)
// PORTS
//  clk            in    1    system clock, all logic on rising edge
//  rst_n          in    1    synchronous reset, active low
//  start          in    1    start a new load; sampled only in IDLE
//  tamanho_in     in    2    size code: 00=2x2, 01=3x3, 10=4x4, 11=illegal
//  elem_valid     in    1    elem_data valid
//  elem_data      in    8    matrix element, row-major order
//  elem_ready     out   1    element accepted when elem_valid & elem_ready
//  matriz         out   200  packed matrix driven to the ALU
//  tamanho_matriz out   2    size code driven to the ALU (registered copy of tamanho_in)
//  det_in         in    8    determinant from ALU (signed)
//  overflow_in    in    1    overflow flag from ALU
//  done_in        in    1    ALU done flag
//  result_valid   out   1    det_out/overflow_out valid; held until result_ready
//  result_ready   in    1    consumer accepts result
//  det_out        out   8    captured determinant (signed)
//  overflow_out   out   1    captured overflow flag
//  busy           out   1    high in every state except IDLE
//  error          out   1    one-cycle pulse on illegal size code at start
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; matriz=0, tamanho_matriz=00, det_out=0, overflow_out=0,
//   result_valid=0, elem_ready=0, busy=0, error=0, element counter=0, settle counter=0.
//  Element count N: 00->4, 01->9, 10->16.
//  IDLE: start=1 & tamanho_in!=11 -> LOAD; latch tamanho_matriz, counter=0. start=1 & tamanho_in==11 ->
//   error=1 for one cycle, stay IDLE, matriz unchanged. elem_valid ignored in IDLE.
//  LOAD: elem_ready=1. Each accepted element is written to matriz[8*cnt+7 -: 8], cnt++. When the N-th
//   element is accepted (cnt==N-1) -> SETTLE in the next cycle, elem_ready drops. start ignored.
//  SETTLE: counts SETTLE_CYCLES cycles with matriz/tamanho_matriz frozen, then -> CAPTURE.
//  CAPTURE: if done_in=1, register det_in/overflow_in into det_out/overflow_out, set result_valid -> RESULT;
//   if done_in=0, remain in CAPTURE (no timeout).
//  RESULT: result_valid=1, outputs stable. result_valid & result_ready -> IDLE, result_valid=0 next cycle.
//   start in RESULT is ignored (not queued).
//  Latency: from last accepted element to result_valid high = SETTLE_CYCLES+2 cycles when done_in=1.
//  Bits of matriz above 8*N are not written by a load (see CONFIGURATION).
//  Reset mid-load or mid-result: immediately returns to IDLE with all outputs at reset values;
//   partially loaded data is discarded.
// CONFIGURATION
//  ZERO_FILL_EN defined: on the IDLE->LOAD transition, matriz is cleared to 0, so unused upper bits are
//   always 0 for the ALU.
//  ZERO_FILL_EN undefined: matriz is not cleared; unused upper bits keep values from earlier loads.
// TESTING
//  2x2 load 3,1,2,4 (start, tamanho_in=00) -> matriz[31:0]=32'h04020103, det_out=10, overflow_out=0,
//   result_valid exactly SETTLE_CYCLES+2 cycles after the 4th element.
//  3x3 identity (1,0,0,0,1,0,0,0,1) -> det_out=1; then 4x4 with elements 100 on the diagonal -> overflow_out=1.
//  start with tamanho_in=11 -> error pulse of exactly 1 cycle, busy stays 0, matriz unchanged.
//  elem_valid toggled 1/0 every cycle during a 3x3 load -> only handshaken elements counted, 9 accepted.
//  rst_n=0 after the 5th of 16 elements -> next cycle IDLE, matriz=0, result_valid=0; a fresh 2x2 load succeeds.
//  result_ready held low 10 cycles -> result_valid and det_out stable; start pulses ignored; with ZERO_FILL_EN,
//   4x4 load then 2x2 load -> matriz[199:32]=0.

Source files
------------

// File: rtl/carregador_matriz.sv
// Loads up to 16 signed elements row-major into the packed matrix bus, then returns the determinant result.
// Latency: result_valid rises SETTLE_CYCLES+2 cycles after the last element's handshake cycle, given done_in=1.
// Backpressure: elem_ready is high only in LOAD, and the result is held until result_ready.
// Optional macro ZERO_FILL_EN: when defined, matriz is cleared at the start of each load.
module carregador_matriz #(
    parameter int ELEM_W        = 8,
    parameter int BUS_W         = 200,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        tamanho_in,
    input  logic              elem_valid,
    input  logic [ELEM_W-1:0] elem_data,
    output logic              elem_ready,
    output logic [BUS_W-1:0]  matriz,
    output logic [1:0]        tamanho_matriz,
    input  logic [ELEM_W-1:0] det_in,
    input  logic              overflow_in,
    input  logic              done_in,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ELEM_W-1:0] det_out,
    output logic              overflow_out,
    output logic              busy,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_RESULT
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] cnt;
    logic [4:0] cnt_last;
    logic [3:0] settle_cnt;
    logic       start_ok;
    logic       accept;
    logic       last_elem;

    // Index of the final element for the latched size code
    always_comb begin
        cnt_last = 5'd15;
        case (tamanho_matriz)
            2'b00:   cnt_last = 5'd3;
            2'b01:   cnt_last = 5'd8;
            default: cnt_last = 5'd15;
        endcase
    end

    assign start_ok  = start && (tamanho_in != 2'b11);
    assign accept    = (state == S_LOAD) && elem_valid;
    assign last_elem = accept && (cnt == cnt_last);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived handshake outputs
    always_comb begin
        state_nxt    = state;
        elem_ready   = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_ok) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                elem_ready = 1'b1;
                if (last_elem) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (done_in) begin
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: element packing, settle timing, result capture and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            matriz         <= '0;
            tamanho_matriz <= 2'b00;
            det_out        <= '0;
            overflow_out   <= 1'b0;
            error          <= 1'b0;
            cnt            <= '0;
            settle_cnt     <= '0;
        end else begin
            error <= (state == S_IDLE) && start && (tamanho_in == 2'b11);
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        tamanho_matriz <= tamanho_in;
                        cnt            <= '0;
`ifdef ZERO_FILL_EN
                        matriz         <= '0;
`else
                        matriz         <= matriz;
`endif
                    end
                end
                S_LOAD: begin
                    settle_cnt <= '0;
                    if (accept) begin
                        matriz[ELEM_W*int'(cnt) +: ELEM_W] <= elem_data;
                        cnt <= last_elem ? 5'd0 : cnt + 5'd1;
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                S_CAPTURE: begin
                    if (done_in) begin
                        det_out      <= det_in;
                        overflow_out <= overflow_in;
                    end
                end
                default: begin
                    settle_cnt <= settle_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_matriz.sv
// Directed bench for carregador_matriz: table of loads plus hand-written error and reset sequences.
// Runs each load through start, element handshakes, settle, capture and result handshake.
// Keeps its own model of the matriz bus, including upper bits left over from earlier loads.
module tb_carregador_matriz;

    localparam int SETTLE = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   tamanho_in = 2'b00;
    logic         elem_valid = 1'b0;
    logic [7:0]   elem_data = 8'h00;
    logic         elem_ready;
    logic [199:0] matriz;
    logic [1:0]   tamanho_matriz;
    logic [7:0]   det_in = 8'h00;
    logic         overflow_in = 1'b0;
    logic         done_in = 1'b0;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic [7:0]   det_out;
    logic         overflow_out;
    logic         busy;
    logic         error;

    int n_chk = 0;
    int n_fail = 0;
    logic [199:0] mdl = '0;

    typedef struct packed {
        logic [1:0]   tam;
        logic [4:0]   n;
        logic [127:0] elems;
        logic [7:0]   det;
        logic         ovf;
        logic         toggle;
        logic [3:0]   delay;
        logic [3:0]   hold;
    } vec_t;

    vec_t vecs [4];

    carregador_matriz #(.ELEM_W(8), .BUS_W(200), .SETTLE_CYCLES(SETTLE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .tamanho_in    (tamanho_in),
        .elem_valid    (elem_valid),
        .elem_data     (elem_data),
        .elem_ready    (elem_ready),
        .matriz        (matriz),
        .tamanho_matriz(tamanho_matriz),
        .det_in        (det_in),
        .overflow_in   (overflow_in),
        .done_in       (done_in),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .det_out       (det_out),
        .overflow_out  (overflow_out),
        .busy          (busy),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model_on_start();
`ifdef ZERO_FILL_EN
        mdl = '0;
`else
        mdl = mdl;
`endif
    endtask

    task automatic run_load(input vec_t v);
        int acc;
        int cyc;
        int k;
        int exp_lat;
        logic [7:0] det_held;
        logic       ovf_held;

        done_in     = (v.delay == 4'd0);
        det_in      = (v.delay == 4'd0) ? v.det : 8'h5A;
        overflow_in = (v.delay == 4'd0) ? v.ovf : ~v.ovf;
        tamanho_in  = v.tam;
        start       = 1'b1;
        tick();
        start = 1'b0;
        clear_model_on_start();
        chk("busy_after_start", busy, 1'b1);
        chk("elem_ready_in_load", elem_ready, 1'b1);
        chk("tamanho_latched", tamanho_matriz, v.tam);

        // Feed elements; toggle mode inserts idle cycles with junk data and stray start pulses
        acc = 0;
        cyc = 0;
        while (acc < int'(v.n) && cyc < 100) begin
            elem_valid = !(v.toggle && (cyc % 2 == 1));
            elem_data  = elem_valid ? v.elems[8*acc +: 8] : 8'hEE;
            start      = v.toggle && (cyc % 2 == 1);
            tick();
            if (elem_valid) begin
                mdl[8*acc +: 8] = v.elems[8*acc +: 8];
                acc++;
            end
            cyc++;
        end
        elem_valid = 1'b0;
        start      = 1'b0;
        chk("elem_ready_drops", elem_ready, 1'b0);

        // Edges after the last acceptance edge until result_valid
        k = 0;
        while (!result_valid && k < 60) begin
            if (v.delay != 4'd0 && k == SETTLE + int'(v.delay)) begin
                done_in     = 1'b1;
                det_in      = v.det;
                overflow_in = v.ovf;
            end
            tick();
            k++;
        end
        exp_lat = SETTLE + 1 + int'(v.delay);
        chk("result_latency", k, exp_lat);
        chk("det_out", det_out, v.det);
        chk("overflow_out", overflow_out, v.ovf);
        chk("matriz", matriz, mdl);

        // ALU moves on; captured result and bus must hold while the consumer stalls
        det_held    = v.det;
        ovf_held    = v.ovf;
        done_in     = 1'b0;
        det_in      = 8'hA5;
        overflow_in = ~v.ovf;
        for (int h = 0; h < int'(v.hold); h++) begin
            start = (h % 3 == 0);
            tick();
            chk("result_valid_held", result_valid, 1'b1);
            chk("det_out_held", det_out, det_held);
            chk("overflow_out_held", overflow_out, ovf_held);
        end
        start        = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("result_valid_cleared", result_valid, 1'b0);
        chk("busy_idle", busy, 1'b0);
        tick();
        chk("start_not_queued", busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{tam: 2'b00, n: 5'd4, elems: 128'h04020103, det: 8'd10, ovf: 1'b0,
                    toggle: 1'b0, delay: 4'd0, hold: 4'd0};
        vecs[1] = '{tam: 2'b01, n: 5'd9, elems: '0, det: 8'd1, ovf: 1'b0,
                    toggle: 1'b1, delay: 4'd0, hold: 4'd2};
        vecs[2] = '{tam: 2'b10, n: 5'd16, elems: '0, det: 8'h00, ovf: 1'b1,
                    toggle: 1'b0, delay: 4'd3, hold: 4'd10};
        vecs[3] = '{tam: 2'b00, n: 5'd4, elems: 128'h0501FD02, det: 8'd13, ovf: 1'b0,
                    toggle: 1'b0, delay: 4'd1, hold: 4'd0};
        for (int i = 0; i < 9; i++) vecs[1].elems[8*i +: 8] = (i % 4 == 0) ? 8'd1 : 8'd0;
        for (int i = 0; i < 16; i++) vecs[2].elems[8*i +: 8] = (i % 5 == 0) ? 8'd100 : 8'd0;

        // Reset state
        tick();
        tick();
        chk("rst_matriz", matriz, 200'd0);
        chk("rst_tamanho", tamanho_matriz, 2'b00);
        chk("rst_det_out", det_out, 8'd0);
        chk("rst_overflow_out", overflow_out, 1'b0);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_elem_ready", elem_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_error", error, 1'b0);
        rst_n = 1'b1;

        // elem_valid in IDLE must not write the bus
        elem_valid = 1'b1;
        elem_data  = 8'h77;
        tick();
        elem_valid = 1'b0;
        chk("idle_ignores_elem", matriz, 200'd0);

        for (int i = 0; i < 4; i++) begin
            run_load(vecs[i]);
            if (i == 0) chk("matriz_2x2_literal", matriz[31:0], 32'h04020103);
        end

        // Illegal size code: one-cycle error pulse, no state change
        tamanho_in = 2'b11;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("error_pulse", error, 1'b1);
        chk("error_busy", busy, 1'b0);
        chk("error_matriz_kept", matriz, mdl);
        tick();
        chk("error_one_cycle", error, 1'b0);
        chk("error_still_idle", busy, 1'b0);

        // Reset after the 5th of 16 elements
        tamanho_in = 2'b10;
        start      = 1'b1;
        tick();
        start = 1'b0;
        clear_model_on_start();
        for (int i = 0; i < 5; i++) begin
            elem_valid = 1'b1;
            elem_data  = 8'(9 + i);
            tick();
            mdl[8*i +: 8] = 8'(9 + i);
        end
        elem_valid = 1'b0;
        chk("partial_matriz", matriz, mdl);
        rst_n = 1'b0;
        tick();
        mdl = '0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_matriz", matriz, 200'd0);
        chk("midrst_result_valid", result_valid, 1'b0);
        chk("midrst_elem_ready", elem_ready, 1'b0);
        chk("midrst_tamanho", tamanho_matriz, 2'b00);
        rst_n = 1'b1;
        tick();
        run_load(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
